sm_regdump: RTL



---
 rtl/sm_regdump.sv | 103 ++++++++++
 1 files changed

// File: rtl/sm_regdump.sv
// Debug-port register dumper for schoolMIPS: walks regAddr 0..LAST_REG and streams each word MSB-first on valid/ready.
// Optional two-byte header (0xA5, LAST_REG+1) when SM_REGDUMP_HEADER_EN is defined.
module sm_regdump #(
  parameter int unsigned LAST_REG = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

`ifdef SM_REGDUMP_HEADER_EN
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, SETUP, SEND, DONE} state_t;
  localparam logic [7:0] HDR_LEN = 8'(LAST_REG + 1);
`else
  typedef enum logic [2:0] {IDLE, SETUP, SEND, DONE} state_t;
`endif

  localparam logic [4:0] LAST_IDX = 5'(LAST_REG);

  state_t      state, state_next;
  logic [4:0]  idx;
  logic [31:0] shreg;
  logic [1:0]  bcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_data    = '0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef SM_REGDUMP_HEADER_EN
          state_next = HDR0;
`else
          state_next = SETUP;
`endif
        end
      end
`ifdef SM_REGDUMP_HEADER_EN
      HDR0: begin
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        if (tx_ready) state_next = HDR1;
      end
      HDR1: begin
        tx_valid = 1'b1;
        tx_data  = HDR_LEN;
        if (tx_ready) state_next = SETUP;
      end
`endif
      SETUP: state_next = SEND;
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = shreg[31:24];
        if (tx_ready && bcnt == 2'd3)
          state_next = (idx == LAST_IDX) ? DONE : SETUP;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      shreg <= '0;
      bcnt  <= '0;
    end else begin
      case (state)
        IDLE: if (start) idx <= '0;
        SETUP: begin
          shreg <= regData;
          bcnt  <= '0;
        end
        SEND: begin
          if (tx_ready) begin
            shreg <= {shreg[23:0], 8'h00};
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3 && idx != LAST_IDX) idx <= idx + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign regAddr = idx;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule
